// File: rtl/cam_fifo_reader.sv
// cam_fifo_reader: read side of the camera capture FIFO.
// Pops {byte, href, vsyn} words, locks onto a frame from the vsyn flag,
// pairs href bytes into RGB565 pixels and emits them with x/y coordinates
// over a valid/ready handshake. One frame per start.
module cam_fifo_reader #(
    parameter int H_PIX   = 640,
    parameter int V_LINES = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [9:0]  fifo_data,
    input  logic        fifo_empty,
    output logic        fifo_rd,
    output logic [15:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_last,
    output logic        busy,
    output logic        frame_done,
    output logic        line_err
);

    typedef enum logic [2:0] {IDLE, WAIT_VS, IN_VS, ACTIVE, DONE} state_t;

    localparam logic [9:0] XEND  = 10'(H_PIX);
    localparam logic [9:0] XLAST = 10'(H_PIX - 1);
    localparam logic [8:0] YLAST = 9'(V_LINES - 1);

    state_t      state;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        phase;     // 1: high byte of the current pixel is held in hi
    logic        line_has;  // at least one href byte seen in the current line
    logic [7:0]  hi;

    logic        head_vsyn;
    logic        head_href;
    logic [7:0]  head_byte;
    logic        stall;
    logic        consume;

    // Decode the head word and decide whether this state swallows it
    always_comb begin
        head_vsyn = fifo_data[0];
        head_href = fifo_data[1];
        head_byte = fifo_data[9:2];
        stall     = pix_valid && !pix_ready;
        consume   = 1'b0;
        case (state)
            WAIT_VS: consume = 1'b1;
            IN_VS:   consume = head_vsyn;   // exit word stays for ACTIVE
            ACTIVE:  consume = !head_vsyn;  // vsyn here ends the frame unpopped
            default: consume = 1'b0;
        endcase
        fifo_rd = consume && !fifo_empty && !stall;
    end

    // Frame FSM, line/pixel counters and the output pixel register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            phase      <= 1'b0;
            line_has   <= 1'b0;
            hi         <= '0;
            pix_data   <= '0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_valid  <= 1'b0;
            pix_last   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            line_err   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            // Accepted pixel retires unless a new one loads below on this edge
            if (pix_valid && pix_ready) begin
                pix_valid <= 1'b0;
                pix_last  <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= WAIT_VS;
                        busy     <= 1'b1;
                        line_err <= 1'b0;
                        x        <= '0;
                        y        <= '0;
                        phase    <= 1'b0;
                        line_has <= 1'b0;
                    end
                end
                WAIT_VS: begin
                    if (fifo_rd && head_vsyn) state <= IN_VS;
                end
                IN_VS: begin
                    if (!fifo_empty && !head_vsyn) state <= ACTIVE;
                end
                ACTIVE: begin
                    if (!fifo_empty && head_vsyn) begin
                        // Frame ended before all lines arrived
                        line_err <= 1'b1;
                        state    <= DONE;
                    end else if (fifo_rd) begin
                        if (head_href) begin
                            line_has <= 1'b1;
                            if (x == XEND) begin
                                line_err <= 1'b1;  // overlong line, byte dropped
                            end else if (!phase) begin
                                hi    <= head_byte;
                                phase <= 1'b1;
                            end else begin
                                pix_data  <= {hi, head_byte};
                                pix_x     <= x;
                                pix_y     <= y;
                                pix_last  <= (x == XLAST) && (y == YLAST);
                                pix_valid <= 1'b1;
                                phase     <= 1'b0;
                                x         <= x + 10'd1;
                            end
                        end else if (line_has) begin
                            // Line end: check length, drop any dangling byte
                            if (x != XEND || phase) line_err <= 1'b1;
                            x        <= '0;
                            phase    <= 1'b0;
                            line_has <= 1'b0;
                            y        <= y + 9'd1;
                            if (y == YLAST) state <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Hold the done pulse until the last pixel has left
                    if (!pix_valid) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_fifo_reader.sv
// Directed bench for cam_fifo_reader with H_PIX=4, V_LINES=2.
module tb_cam_fifo_reader;

    typedef struct packed {
        logic [15:0] d;
        logic [9:0]  x;
        logic [8:0]  y;
        logic        last;
    } pix_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  fifo_data;
    logic        fifo_empty;
    logic        fifo_rd;
    logic [15:0] pix_data;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic        pix_last;
    logic        busy;
    logic        frame_done;
    logic        line_err;

    // FIFO model: show-ahead head, popped on fifo_rd
    logic [9:0]  mem [0:1023];
    logic [9:0]  rd_ptr = '0;
    logic [9:0]  wr_ptr = '0;
    logic        gate_empty = 1'b0;

    assign fifo_empty = gate_empty || (rd_ptr == wr_ptr);
    assign fifo_data  = mem[rd_ptr];

    always #5 clk = ~clk;

    always @(posedge clk) if (fifo_rd) rd_ptr <= rd_ptr + 10'd1;

    cam_fifo_reader #(.H_PIX(4), .V_LINES(2)) dut (
        .clk(clk), .rst(rst), .start(start),
        .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
        .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_last(pix_last),
        .busy(busy), .frame_done(frame_done), .line_err(line_err)
    );

    int   errors = 0;
    int   checks = 0;
    int   done_cnt = 0;
    int   stall_rd = 0;
    int   gate_rd = 0;
    pix_t cap_q[$];
    pix_t exp_q[$];
    pix_t exp_tbl[8];

    // Observe away from the active edge; handshakes complete on the next posedge
    always @(negedge clk) begin
        if (rst && pix_valid && pix_ready) cap_q.push_back({pix_data, pix_x, pix_y, pix_last});
        if (fifo_rd && pix_valid && !pix_ready) stall_rd++;
        if (gate_empty && fifo_rd) gate_rd++;
        if (frame_done) done_cnt++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b, input logic href, input logic vsyn);
        mem[wr_ptr] = {b, href, vsyn};
        wr_ptr = wr_ptr + 10'd1;
    endtask

    // Partial frame, vsyn, blanking, line 0, blanking, then vsyn or line 1
    task automatic push_frame(input int line0_bytes, input bit prem_vsyn);
        for (int i = 0; i < 3; i++) push(8'hAA, 1'b1, 1'b0);
        push(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) push(8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) push(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < line0_bytes; i++) push(8'(i), 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) push(8'h00, 1'b0, 1'b0);
        if (prem_vsyn) begin
            push(8'h5A, 1'b0, 1'b1);
            push(8'h00, 1'b0, 1'b1);
        end else begin
            for (int i = 8; i < 16; i++) push(8'(i), 1'b1, 1'b0);
            for (int i = 0; i < 2; i++) push(8'h00, 1'b0, 1'b0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready always high, mode 1: ready toggles every cycle.
    // gate_at >= 0: once that many pixels are out, hold the FIFO empty 20 cycles.
    task automatic run_frame(input string name, input int mode, input int gate_at);
        bit   gated = 1'b0;
        int   cyc = 0;
        logic [9:0] rd_snap;
        int   cap_snap;
        cap_q.delete();
        done_cnt = 0;
        stall_rd = 0;
        gate_rd  = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (done_cnt == 0 && cyc < 2000) begin
            pix_ready = (mode == 1) ? ~pix_ready : 1'b1;
            if (gate_at >= 0 && !gated && cap_q.size() == gate_at) begin
                gated = 1'b1;
                pix_ready = 1'b1;
                gate_empty = 1'b1;
                tick(); tick();
                rd_snap  = rd_ptr;
                cap_snap = cap_q.size();
                for (int i = 0; i < 18; i++) tick();
                chk({name, " gate no pop"}, 64'(rd_ptr), 64'(rd_snap));
                chk({name, " gate no pixel"}, 64'(cap_q.size()), 64'(cap_snap));
                chk({name, " gate busy held"}, 64'(busy), 64'd1);
                chk({name, " gate rd strobe"}, 64'(gate_rd), 64'd0);
                gate_empty = 1'b0;
            end
            tick();
            cyc++;
        end
        pix_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk({name, " frame_done pulses"}, 64'(done_cnt), 64'd1);
        chk({name, " busy after"}, 64'(busy), 64'd0);
        chk({name, " pop while stalled"}, 64'(stall_rd), 64'd0);
    endtask

    task automatic cmp_pixels(input string name);
        chk({name, " pixel count"}, 64'(cap_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
            chk($sformatf("%s pixel %0d {d,x,y,last}", name, i), 64'(cap_q[i]), 64'(exp_q[i]));
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        //                 data      x      y     last
        exp_tbl[0] = {16'h0001, 10'd0, 9'd0, 1'b0};
        exp_tbl[1] = {16'h0203, 10'd1, 9'd0, 1'b0};
        exp_tbl[2] = {16'h0405, 10'd2, 9'd0, 1'b0};
        exp_tbl[3] = {16'h0607, 10'd3, 9'd0, 1'b0};
        exp_tbl[4] = {16'h0809, 10'd0, 9'd1, 1'b0};
        exp_tbl[5] = {16'h0A0B, 10'd1, 9'd1, 1'b0};
        exp_tbl[6] = {16'h0C0D, 10'd2, 9'd1, 1'b0};
        exp_tbl[7] = {16'h0E0F, 10'd3, 9'd1, 1'b1};

        // Reset state
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        tick();
        chk("reset outputs", 64'({fifo_rd, pix_valid, pix_last, busy, frame_done, line_err}), 64'd0);
        chk("reset pixel regs", 64'({pix_data, pix_x, pix_y}), 64'd0);

        // Clean frame, ready held high
        push_frame(8, 1'b0);
        run_frame("normal", 0, -1);
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(exp_tbl[i]);
        cmp_pixels("normal");
        chk("normal line_err", 64'(line_err), 64'd0);

        // Same frame under back-pressure
        push_frame(8, 1'b0);
        run_frame("toggle", 1, -1);
        cmp_pixels("toggle");
        chk("toggle line_err", 64'(line_err), 64'd0);

        // Short line 0: dangling byte dropped, line 1 unaffected
        push_frame(7, 1'b0);
        run_frame("short", 0, -1);
        exp_q.delete();
        for (int i = 0; i < 8; i++) if (i != 3) exp_q.push_back(exp_tbl[i]);
        cmp_pixels("short");
        chk("short line_err", 64'(line_err), 64'd1);

        // vsyn after line 0: frame cut short, vsyn word left at head
        wr_ptr = rd_ptr;
        push_frame(8, 1'b1);
        run_frame("prem", 0, -1);
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(exp_tbl[i]);
        cmp_pixels("prem");
        chk("prem line_err", 64'(line_err), 64'd1);
        chk("prem head word", 64'({fifo_empty, fifo_data}), 64'({1'b0, 8'h5A, 1'b0, 1'b1}));
        wr_ptr = rd_ptr;

        // FIFO runs dry mid-line for 20 cycles
        push_frame(8, 1'b0);
        run_frame("gate", 0, 2);
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(exp_tbl[i]);
        cmp_pixels("gate");
        chk("gate line_err", 64'(line_err), 64'd0);

        // Reset while a pixel is held under back-pressure
        push_frame(8, 1'b0);
        cap_q.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 200 && cap_q.size() < 2; i++) tick();
        pix_ready = 1'b0;
        for (int i = 0; i < 200 && !pix_valid; i++) tick();
        tick();
        chk("midreset pending pixel", 64'(pix_valid), 64'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("midreset outputs", 64'({fifo_rd, pix_valid, pix_last, busy, frame_done, line_err}), 64'd0);
        chk("midreset pixel regs", 64'({pix_data, pix_x, pix_y}), 64'd0);
        pix_ready = 1'b1;
        tick();
        push_frame(8, 1'b0);
        run_frame("after reset", 0, -1);
        cmp_pixels("after reset");
        chk("after reset line_err", 64'(line_err), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cam_fifo_reader.md
# cam_fifo_reader

Read side of the camera capture FIFO. Pops the 10-bit words the capture block writes (`{data[7:0], Href, Vsyn}`), finds frame and line boundaries from the stored sync flags, and pairs consecutive Href bytes into RGB565 pixels. Pixels leave with x/y coordinates over a valid/ready handshake to the downstream colour-classification / frame-buffer logic. One frame is captured per `start`.

## Interface

Parameters:
- `H_PIX`, 640, active pixels per line (2·H_PIX bytes)
- `V_LINES`, 480, active lines per frame

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous reset, active-low
- `start`  in  1  arm capture of one frame; sampled only in IDLE
- `fifo_data`  in  10  show-ahead head word `{byte[7:0], href, vsyn}`; valid when `fifo_empty`=0
- `fifo_empty`  in  1  FIFO empty flag
- `fifo_rd`  out  1  pop strobe; head advances after this cycle
- `pix_data`  out  16  RGB565 pixel `{first byte, second byte}`
- `pix_x`  out  10  pixel column, 0..H_PIX-1
- `pix_y`  out  9  pixel line, 0..V_LINES-1
- `pix_valid`  out  1  output pixel valid
- `pix_ready`  in  1  downstream accepts
- `pix_last`  out  1  qualifies last pixel of frame (x=H_PIX-1, y=V_LINES-1)
- `busy`  out  1  capture in progress
- `frame_done`  out  1  one-cycle pulse at end of frame
- `line_err`  out  1  sticky: line byte count ≠ 2·H_PIX or frame short; cleared on accepted `start`

## Operation

- States: IDLE, WAIT_VS, IN_VS, ACTIVE, DONE.
- IDLE: `fifo_rd`=0, `busy`=0. `start`=1 → WAIT_VS, clear `line_err`, x=y=0, byte phase=0, `busy`=1.
- WAIT_VS: pop and discard every word; word with vsyn=1 → IN_VS. Synchronises to the first complete frame.
- IN_VS: pop/discard while vsyn=1; first word with vsyn=0 is not popped in IN_VS → ACTIVE.
- ACTIVE, per popped word:
  - href=1: byte phase 0 → latch as high byte, phase=1. Phase 1 → form pixel `{hi, byte}`, load output register with x,y, phase=0, x++. Bytes once x=H_PIX are discarded and set `line_err`.
  - href=0, vsyn=0 following ≥1 href byte (line end): if x≠H_PIX or phase=1 set `line_err`; drop dangling byte; x=0, phase=0, y++. If y becomes V_LINES → DONE.
  - href=0, vsyn=0 with no bytes in current line: blanking, discarded.
  - vsyn=1: premature frame end → set `line_err`, → DONE (word not popped).
- DONE: `frame_done`=1 for exactly one cycle, only after the last pixel is accepted (`pix_valid`=0); → IDLE. No pops in DONE.
- `start` while `busy`=1 is ignored.
- Words remaining in the FIFO after DONE stay there; the next `start` discards them via WAIT_VS.

## Timing

- Reset (`rst`=0 at a `clk` edge): state IDLE; `fifo_rd`, `pix_valid`, `pix_last`, `busy`, `frame_done`, `line_err` = 0; `pix_data`, `pix_x`, `pix_y` = 0. Takes priority over every other event, including mid-frame and mid-handshake; a pending pixel is dropped.
- `fifo_rd` is combinational: 1 iff state ∈ {WAIT_VS, IN_VS, ACTIVE}, `fifo_empty`=0, the head word is consumed in this state (not the IN_VS exit word or the ACTIVE vsyn word), and not stalled.
- Stall: `pix_valid`=1 and `pix_ready`=0 → `fifo_rd`=0. Output register holds `pix_data`/`pix_x`/`pix_y`/`pix_last` stable until accepted.
- Pixel latency: `pix_valid` rises the cycle after the second byte is popped. Sustained throughput is 1 pixel / 2 cycles. Popping the next pixel's bytes continues while the current pixel waits only if `pix_ready`=1 that cycle.
- Handshake: transfer on the `clk` edge with `pix_valid`=`pix_ready`=1. `pix_valid` drops the next cycle unless a new pixel loads on the same edge.
- x, y wrap is impossible by construction: x saturates at H_PIX, and y terminates at V_LINES.

## Test plan

- Reset mid-frame (after 100 pixels, `pix_valid`=1, `pix_ready`=0), `rst`=0 one cycle → all outputs 0, state IDLE; next `start` captures a clean frame from the next vsyn.
- H_PIX=4, V_LINES=2, FIFO preloaded with partial frame, vsyn, blanking, 2 lines of 8 href bytes 0x00..0x0F, blanking; `pix_ready`=1, `start` → 8 pixels 0x0001,0x0203,…,0x0E0F at (0,0)…(3,1). `pix_last` only on (3,1). One `frame_done` pulse. `line_err`=0.
- Same frame with `pix_ready` toggling 1/0 every cycle → identical pixel sequence; `fifo_rd`=0 on every stalled cycle; no pixel lost or duplicated.
- Line 0 carries 7 bytes → `line_err`=1. Pixels (0..2,0) emitted and dangling byte dropped; line 1 output normal at y=1.
- vsyn word after line 0 only → `line_err`=1, `frame_done` pulse; the vsyn word remains at FIFO head.
- `fifo_empty` asserted for 20 cycles mid-line → no pops, no pixels, state held; resumes with correct x.
